// File: rtl/risc_loader_if.sv
// risc_loader_if: byte stream, memory write port and CPU control bundle
// around the program loader.
//   slave  : loader side (consumes stream, drives memory writes and CPU reset)
//   master : environment side (stream source, memory, CPU core)
// Signals:
//   in_valid/in_data/in_ready : byte stream handshake
//   mem_wr/mem_addr/mem_data  : registered memory write port
//   cpu_rst/cpu_halt          : CPU core reset out, halt flag in
//   start/done/cycle_count    : re-arm pulse, completion flag, run-cycle count
interface risc_loader_if #(
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned DWIDTH = 8
) ();
   logic              in_valid;
   logic [DWIDTH-1:0] in_data;
   logic              in_ready;
   logic              mem_wr;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_data;
   logic              cpu_rst;
   logic              cpu_halt;
   logic              start;
   logic              done;
   logic [15:0]       cycle_count;

   modport slave (
      input  in_valid, in_data, cpu_halt, start,
      output in_ready, mem_wr, mem_addr, mem_data, cpu_rst, done, cycle_count
   );

   modport master (
      output in_valid, in_data, cpu_halt, start,
      input  in_ready, mem_wr, mem_addr, mem_data, cpu_rst, done, cycle_count
   );
endinterface

// File: rtl/risc_loader.sv
// risc_loader: loads a length-prefixed byte stream into program memory,
// holds the CPU in reset for RST_CYCLES more cycles, then counts CPU run
// cycles until the core halts. A start pulse in DONE re-arms the loader.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : risc_loader_if.slave (stream in, memory write out, CPU control)
module risc_loader #(
   parameter int unsigned AWIDTH     = 5,
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   risc_loader_if.slave bus
);

   localparam int unsigned LW = AWIDTH + 1;
   localparam int unsigned CW = (DWIDTH > LW) ? DWIDTH : LW;
   localparam int unsigned BW = 4;
   localparam logic [CW-1:0] MAX_LEN   = CW'(2 ** AWIDTH);
   localparam logic [BW-1:0] BOOT_LAST = BW'(RST_CYCLES - 1);

   localparam logic [2:0] ST_LEN  = 3'd0;
   localparam logic [2:0] ST_DATA = 3'd1;
   localparam logic [2:0] ST_BOOT = 3'd2;
   localparam logic [2:0] ST_RUN  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   logic [2:0]        state_q,  state_d;
   logic [LW-1:0]     len_q,    len_d;
   logic [LW-1:0]     idx_q,    idx_d;
   logic [BW-1:0]     boot_q,   boot_d;
   logic [15:0]       count_q,  count_d;
   logic              ready_q,  ready_d;
   logic              wr_q,     wr_d;
   logic [AWIDTH-1:0] addr_q,   addr_d;
   logic [DWIDTH-1:0] data_q,   data_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q,   done_d;

   logic              accept_c;
   logic [CW-1:0]     len_in_c;

   assign accept_c = bus.in_valid & ready_q;
   assign len_in_c = CW'(bus.in_data);

   // Next-state and next-output logic; registered outputs track the next state.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      boot_d    = boot_q;
      count_d   = count_q;
      wr_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;

      case (state_q)
         ST_LEN: begin
            if (accept_c) begin
               idx_d  = '0;
               boot_d = '0;
               if (len_in_c == '0) begin
                  state_d = ST_BOOT;
               end else begin
                  // Lengths beyond the memory depth are clamped to a full load.
                  len_d   = (len_in_c > MAX_LEN) ? LW'(MAX_LEN) : LW'(len_in_c);
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept_c) begin
               wr_d   = 1'b1;
               addr_d = idx_q[AWIDTH-1:0];
               data_d = bus.in_data;
               idx_d  = idx_q + LW'(1);
               if ((idx_q + LW'(1)) == len_q) begin
                  boot_d  = '0;
                  state_d = ST_BOOT;
               end
            end
         end
         ST_BOOT: begin
            if (boot_q == BOOT_LAST) begin
               state_d = ST_RUN;
            end else begin
               boot_d = boot_q + BW'(1);
            end
         end
         ST_RUN: begin
            if (bus.cpu_halt) begin
               state_d = ST_DONE;
            end else if (count_q != 16'hFFFF) begin
               count_d = count_q + 16'd1;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               count_d = '0;
               state_d = ST_LEN;
            end
         end
         default: begin
            state_d = ST_LEN;
         end
      endcase

      ready_d   = (state_d == ST_LEN) || (state_d == ST_DATA);
      cpu_rst_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_BOOT);
      done_d    = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LEN;
         len_q     <= '0;
         idx_q     <= '0;
         boot_q    <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         boot_q    <= boot_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
      end
   end

   assign bus.in_ready    = ready_q;
   assign bus.mem_wr      = wr_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_data    = data_q;
   assign bus.cpu_rst     = cpu_rst_q;
   assign bus.done        = done_q;
   assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_risc_loader.sv
// tb_risc_loader: directed and randomized checks of risc_loader against a
// transaction-level reference (expected write list, boot length, run count).
module tb_risc_loader;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 8;
   localparam int unsigned RC    = 2;
   localparam int unsigned DEPTH = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   risc_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
   risc_loader #(.AWIDTH(AW), .DWIDTH(DW), .RST_CYCLES(RC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] got_q[$];
   int          got_cyc[$];
   logic [15:0] exp_q[$];
   logic [7:0]  stream_q[$];

   // Write-port monitor: each pulse becomes {addr, data}.
   always @(negedge clk) begin
      if (bus.mem_wr === 1'b1) begin
         got_q.push_back({3'b000, bus.mem_addr, bus.mem_data});
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: length byte clamped to memory depth, data byte k goes to address k.
   task automatic build_expect();
      int n;
      n = int'(stream_q[0]);
      if (n > int'(DEPTH)) n = int'(DEPTH);
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back({3'b000, AW'(k), stream_q[k+1]});
   endtask

   task automatic send_stream(input int gap_max, input bit noisy);
      foreach (stream_q[i]) begin
         repeat ($urandom_range(gap_max, 0)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            if (noisy) begin
               bus.cpu_halt = 1'($urandom);
               bus.start    = 1'($urandom);
            end
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = stream_q[i];
         check("in_ready_load", 32'(bus.in_ready), 32'd1);
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_boot();
      check("in_ready_boot", 32'(bus.in_ready), 32'd0);
      check("cpu_rst_boot", 32'(bus.cpu_rst), 32'd1);
      repeat (RC - 1) begin
         tick();
         check("cpu_rst_hold", 32'(bus.cpu_rst), 32'd1);
      end
      tick();
      check("cpu_rst_release", 32'(bus.cpu_rst), 32'd0);
      check("done_run", 32'(bus.done), 32'd0);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   // Called on the first RUN cycle; halts the CPU after r running cycles.
   task automatic run_cpu(input int r);
      bus.cpu_halt = 1'b0;
      bus.start    = 1'b0;
      repeat (r) tick();
      check("done_before_halt", 32'(bus.done), 32'd0);
      bus.cpu_halt = 1'b1;
      tick();
      bus.cpu_halt = 1'b0;
      check("done_after_halt", 32'(bus.done), 32'd1);
      check("cycle_count", 32'(bus.cycle_count), 32'(r > 65535 ? 65535 : r));
      check("cpu_rst_done", 32'(bus.cpu_rst), 32'd0);
      repeat (3) begin
         bus.cpu_halt = 1'($urandom);
         tick();
      end
      bus.cpu_halt = 1'b0;
      check("count_frozen", 32'(bus.cycle_count), 32'(r > 65535 ? 65535 : r));
      check("done_held", 32'(bus.done), 32'd1);
   endtask

   task automatic restart();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_done", 32'(bus.done), 32'd0);
      check("restart_count", 32'(bus.cycle_count), 32'd0);
      check("restart_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("restart_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic load_and_run(input string tag, input int gap_max, input bit noisy, input int r);
      got_q.delete();
      got_cyc.delete();
      build_expect();
      send_stream(gap_max, noisy);
      check_boot();
      compare_writes(tag);
      run_cpu(r);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.cpu_halt = 1'b0;
      bus.start    = 1'b0;
      tick();
      tick();
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_data", 32'(bus.mem_data), 32'd0);
      check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_count", 32'(bus.cycle_count), 32'd0);
      rst = 1'b0;
      tick();

      // Three-byte program, back-to-back writes.
      stream_q = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
      load_and_run("three", 0, 1'b0, 5);
      check("three_n", 32'(got_cyc.size()), 32'd3);
      if (got_cyc.size() == 3) begin
         check("three_consec0", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
         check("three_consec1", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
      end
      restart();

      // Empty program, seven run cycles.
      stream_q = '{8'h00};
      load_and_run("empty", 0, 1'b0, 7);
      restart();

      // Oversized length clamps to a full memory; a trailing byte is refused.
      stream_q = '{8'h40};
      for (int i = 0; i < int'(DEPTH); i++) stream_q.push_back(8'($urandom));
      got_q.delete();
      got_cyc.delete();
      build_expect();
      send_stream(0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      check_boot();
      bus.in_valid = 1'b0;
      compare_writes("clamp");
      run_cpu(3);
      restart();

      // Gapped valid during DATA.
      stream_q = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
      load_and_run("gapped", 1, 1'b0, 2);
      restart();

      // start during RUN has no effect.
      stream_q = '{8'h00};
      got_q.delete();
      send_stream(0, 1'b0);
      check_boot();
      repeat (3) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_in_run_done", 32'(bus.done), 32'd0);
      check("start_in_run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      check("start_in_run_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) tick();
      bus.cpu_halt = 1'b1;
      tick();
      bus.cpu_halt = 1'b0;
      check("start_in_run_count", 32'(bus.cycle_count), 32'd6);
      check("start_in_run_halt", 32'(bus.done), 32'd1);
      restart();

      // Reset after two of five data bytes; the byte offered during reset is dropped.
      stream_q = '{8'h05, 8'hD0, 8'hD1};
      got_q.delete();
      send_stream(0, 1'b0);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h03;
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
      check("abort_ready", 32'(bus.in_ready), 32'd1);
      check("abort_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      tick();
      check("abort_mem_wr2", 32'(bus.mem_wr), 32'd0);
      exp_q = '{16'h00D0, 16'h01D1};
      compare_writes("abort");
      stream_q = '{8'h01, 8'h7E};
      load_and_run("after_abort", 0, 1'b0, 1);
      restart();

      // Randomized programs with stream gaps and noise on halt/start during load.
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(40, 0);
         stream_q = '{8'(n)};
         for (int i = 0; i < (n > int'(DEPTH) ? int'(DEPTH) : n); i++) stream_q.push_back(8'($urandom));
         load_and_run("random", 2, 1'b1, $urandom_range(20, 0));
         restart();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/risc_loader.md
RISC_LOADER -- requirements
Module: risc_loader

Interface
REQ-001 Parameter AWIDTH, default 5, program/data memory address width.
REQ-002 Parameter DWIDTH, default 8, memory word and stream byte width.
REQ-003 Parameter RST_CYCLES, default 2, CPU reset hold cycles after the last write (legal range 1..15).
REQ-004 Port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  byte stream valid.
REQ-007 Port in_data  input  DWIDTH  byte stream payload.
REQ-008 Port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port mem_wr  output  1  memory write strobe, one cycle per byte.
REQ-010 Port mem_addr  output  AWIDTH  memory write address.
REQ-011 Port mem_data  output  DWIDTH  memory write data.
REQ-012 Port cpu_rst  output  1  reset to the CPU core, active-high.
REQ-013 Port cpu_halt  input  1  halt flag from the CPU core.
REQ-014 Port start  input  1  re-arm pulse, honoured only in DONE.
REQ-015 Port done  output  1  program has run and halted.
REQ-016 Port cycle_count  output  16  CPU run cycles until halt.

Function
REQ-017 The block SHALL implement the states LEN, DATA, BOOT, RUN and DONE.
REQ-018 Handshake: a byte is accepted on any cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in LEN and DATA.
REQ-019 In LEN, the accepted byte is the length N: N=0 -> BOOT with no writes; 1..2^AWIDTH -> DATA; N > 2^AWIDTH is clamped to 2^AWIDTH.
REQ-020 In DATA, the k-th accepted byte (k=0..N-1) SHALL be written to address k; after byte N-1 is accepted -> BOOT.
REQ-021 mem_wr, mem_addr and mem_data SHALL be registered: the write pulse occurs the cycle after acceptance; mem_wr is 0 otherwise.
REQ-022 The address counter SHALL NOT wrap: with N=2^AWIDTH, the last write is to address 2^AWIDTH-1.
REQ-023 BOOT SHALL last exactly RST_CYCLES cycles and then go to RUN.
REQ-024 cpu_rst SHALL be 1 in LEN, DATA and BOOT and 0 in RUN and DONE.
REQ-025 In RUN, cycle_count increments by 1 on each cycle in which cpu_halt=0 and saturates at 0xFFFF.
REQ-026 In RUN, cpu_halt=1 -> DONE on the next edge; cycle_count does not increment on the halt cycle.
REQ-027 In DONE, done=1 and cycle_count is frozen; start=1 -> LEN, clears cycle_count and reasserts cpu_rst.
REQ-028 start SHALL be ignored outside DONE; cpu_halt SHALL be ignored outside RUN.
REQ-029 in_valid is don't-care outside LEN and DATA; no byte is consumed there.

Reset
REQ-030 rst=1 at a clock edge SHALL force: state LEN, in_ready=1, mem_wr=0, mem_addr=0, mem_data=0, cpu_rst=1, done=0, cycle_count=0, address counter 0.
REQ-031 rst mid-load or mid-run SHALL abandon the operation with no further mem_wr; a byte presented during the rst cycle is not accepted.

Verification
REQ-032 Stream 03,A1,B2,C3 -> writes (0,A1),(1,B2),(2,C3) on consecutive cycles; cpu_rst falls 2 cycles after the last acceptance.
REQ-033 Length 00 -> no mem_wr; BOOT then RUN; cpu_halt raised after 7 run cycles -> done=1, cycle_count=7.
REQ-034 Length 40 (hex) followed by 32 bytes -> 32 writes at addresses 0..31, no wrap, no 33rd write; the next byte is not accepted.
REQ-035 in_valid toggled 1,0,1,0 during DATA -> writes occur only on valid cycles; addresses stay contiguous.
REQ-036 rst asserted after 2 of 5 data bytes -> mem_wr stays 0; the next byte is treated as a length.
REQ-037 start in RUN is ignored; start in DONE -> LEN, cycle_count=0, cpu_rst=1, done=0.
